// File: rtl/pcs_an_ctrl.sv
// pcs_an_ctrl: 1000BASE-X PCS auto-negotiation controller.
// Drives the PCS transmit mode and config word, detects partner ability,
// acknowledge and idle sequences, and reports link-partner ability and
// AN completion to management.
module pcs_an_ctrl #(
  parameter int unsigned LINK_TIMER = 1250000,
  parameter int unsigned MATCH_CNT  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mr_an_enable,
  input  logic        mr_restart_an,
  input  logic [15:0] mr_adv_ability,
  input  logic        sync_status,
  input  logic        rx_config_valid,
  input  logic [15:0] rx_Config_Reg,
  input  logic        rx_idle,
  output logic [1:0]  xmit,
  output logic [15:0] tx_Config_Reg,
  output logic        mr_an_complete,
  output logic [15:0] mr_lp_adv_ability,
  output logic [2:0]  an_state
);

  typedef enum logic [2:0] {
    AN_ENABLE          = 3'd0,
    AN_RESTART         = 3'd1,
    ABILITY_DETECT     = 3'd2,
    ACK_DETECT         = 3'd3,
    COMPLETE_ACK       = 3'd4,
    IDLE_DETECT        = 3'd5,
    LINK_OK            = 3'd6,
    AN_DISABLE_LINK_OK = 3'd7
  } an_state_t;

  localparam int unsigned TW = $clog2(LINK_TIMER + 1);
  localparam int unsigned CW = $clog2(MATCH_CNT + 1);
  localparam logic [15:0] ACK_BIT = 16'h4000;

  an_state_t      state;
  an_state_t      state_nxt;
  logic [TW-1:0]  timer_cnt;
  logic           timer_done;
  logic [CW-1:0]  abl_cnt;
  logic [15:0]    abl_val;
  logic           abl_ack;
  logic [CW-1:0]  idle_cnt;
  logic           en_d;

  logic [15:0]    rx_masked;
  logic           abl_cont;
  logic [CW-1:0]  abl_cnt_eff;
  logic [15:0]    abl_val_eff;
  logic           abl_ack_eff;
  logic [CW-1:0]  idle_cnt_eff;
  logic           ability_match;
  logic           ack_match;
  logic           zero_match;
  logic           idle_match;
  logic           state_chg;
  logic           timer_clr;

  // Match counters including this cycle's pulse, so a transition can fire on
  // the edge that samples the final matching ordered set.
  always_comb begin
    rx_masked    = rx_Config_Reg & ~ACK_BIT;
    abl_cont     = (abl_cnt != '0) && (rx_masked == abl_val);
    abl_cnt_eff  = abl_cnt;
    abl_val_eff  = abl_val;
    abl_ack_eff  = abl_ack;
    if (rx_config_valid) begin
      if (abl_cont) begin
        abl_cnt_eff = (abl_cnt == CW'(MATCH_CNT)) ? abl_cnt : abl_cnt + CW'(1);
        abl_ack_eff = abl_ack & rx_Config_Reg[14];
      end else begin
        abl_cnt_eff = CW'(1);
        abl_val_eff = rx_masked;
        abl_ack_eff = rx_Config_Reg[14];
      end
    end
    idle_cnt_eff = idle_cnt;
    if (rx_config_valid) begin
      idle_cnt_eff = '0;
    end else if (rx_idle && (idle_cnt != CW'(MATCH_CNT))) begin
      idle_cnt_eff = idle_cnt + CW'(1);
    end
    ability_match = (abl_cnt_eff >= CW'(MATCH_CNT));
    ack_match     = ability_match && abl_ack_eff;
    zero_match    = ability_match && (abl_val_eff == '0);
    idle_match    = (idle_cnt_eff >= CW'(MATCH_CNT));
  end

  // Next-state decision: per-state rules first, then the global overrides.
  always_comb begin
    state_nxt = state;
    case (state)
      AN_ENABLE:          state_nxt = mr_an_enable ? AN_RESTART : AN_DISABLE_LINK_OK;
      AN_RESTART:         if (timer_done) state_nxt = ABILITY_DETECT;
      ABILITY_DETECT:     if (ability_match && !zero_match) state_nxt = ACK_DETECT;
      ACK_DETECT: begin
        if (zero_match) begin
          state_nxt = AN_ENABLE;
        end else if (ack_match) begin
          state_nxt = (abl_val_eff == mr_lp_adv_ability) ? COMPLETE_ACK : AN_ENABLE;
        end
      end
      COMPLETE_ACK: begin
        if (zero_match) state_nxt = AN_ENABLE;
        else if (timer_done) state_nxt = IDLE_DETECT;
      end
      IDLE_DETECT: begin
        if (zero_match) state_nxt = AN_ENABLE;
        else if (timer_done && idle_match) state_nxt = LINK_OK;
      end
      LINK_OK:            if (ability_match) state_nxt = AN_ENABLE;
      AN_DISABLE_LINK_OK: if (mr_an_enable) state_nxt = AN_ENABLE;
      default:            state_nxt = AN_ENABLE;
    endcase
    if (en_d && !mr_an_enable && (state != AN_DISABLE_LINK_OK)) begin
      state_nxt = AN_ENABLE;
    end
    if (mr_restart_an ||
        (mr_an_enable && !sync_status && (state != AN_ENABLE) && (state != AN_RESTART))) begin
      state_nxt = AN_ENABLE;
    end
    state_chg = (state_nxt != state);
    timer_clr = state_chg && (state_nxt inside {AN_RESTART, COMPLETE_ACK, IDLE_DETECT});
  end

  // State, counters and registered outputs; outputs follow the state one cycle late.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= AN_ENABLE;
      timer_cnt         <= '0;
      timer_done        <= 1'b0;
      abl_cnt           <= '0;
      abl_val           <= '0;
      abl_ack           <= 1'b0;
      idle_cnt          <= '0;
      en_d              <= 1'b0;
      xmit              <= 2'd0;
      tx_Config_Reg     <= '0;
      mr_an_complete    <= 1'b0;
      mr_lp_adv_ability <= '0;
      an_state          <= 3'd0;
    end else begin
      state <= state_nxt;
      en_d  <= mr_an_enable;

      if (state_chg) begin
        abl_cnt  <= '0;
        abl_val  <= '0;
        abl_ack  <= 1'b0;
        idle_cnt <= '0;
      end else begin
        abl_cnt  <= abl_cnt_eff;
        abl_val  <= abl_val_eff;
        abl_ack  <= abl_ack_eff;
        idle_cnt <= idle_cnt_eff;
      end

      // timer_done is a registered flag, so it rises one cycle after the
      // terminal count; that extra cycle gives the LINK_TIMER+1 dwell.
      if (timer_clr) begin
        timer_cnt  <= '0;
        timer_done <= 1'b0;
      end else if (timer_cnt == TW'(LINK_TIMER - 1)) begin
        timer_done <= 1'b1;
      end else begin
        timer_cnt <= timer_cnt + TW'(1);
      end

      if ((state == ABILITY_DETECT) && (state_nxt == ACK_DETECT)) begin
        mr_lp_adv_ability <= abl_val_eff;
      end

      an_state <= state;
      case (state)
        AN_ENABLE, AN_RESTART: begin
          xmit           <= 2'd0;
          tx_Config_Reg  <= '0;
          mr_an_complete <= 1'b0;
        end
        ABILITY_DETECT: begin
          xmit           <= 2'd0;
          tx_Config_Reg  <= mr_adv_ability & ~ACK_BIT;
          mr_an_complete <= 1'b0;
        end
        ACK_DETECT, COMPLETE_ACK: begin
          xmit           <= 2'd0;
          tx_Config_Reg  <= mr_adv_ability | ACK_BIT;
          mr_an_complete <= 1'b0;
        end
        IDLE_DETECT: begin
          xmit           <= 2'd1;
          mr_an_complete <= 1'b0;
        end
        LINK_OK: begin
          xmit           <= 2'd2;
          mr_an_complete <= 1'b1;
        end
        default: begin
          xmit           <= 2'd2;
          mr_an_complete <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcs_an_ctrl.sv
// tb_pcs_an_ctrl: checks pcs_an_ctrl against a queue-based reference model,
// a hand-derived vector table and directed multi-cycle sequences.
module tb_pcs_an_ctrl;

  localparam int LT    = 16;
  localparam int MATCH = 3;

  typedef enum logic [2:0] {
    M_EN = 3'd0, M_RS = 3'd1, M_AB = 3'd2, M_AK = 3'd3,
    M_CA = 3'd4, M_ID = 3'd5, M_OK = 3'd6, M_DIS = 3'd7
  } mst_t;

  typedef struct {
    logic        rst;
    logic        en;
    logic        rs;
    logic [2:0]  an;
    logic [1:0]  xm;
    logic        cp;
    logic [15:0] tx;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        mr_an_enable;
  logic        mr_restart_an;
  logic [15:0] mr_adv_ability;
  logic        sync_status;
  logic        rx_config_valid;
  logic [15:0] rx_Config_Reg;
  logic        rx_idle;
  logic [1:0]  xmit;
  logic [15:0] tx_Config_Reg;
  logic        mr_an_complete;
  logic [15:0] mr_lp_adv_ability;
  logic [2:0]  an_state;

  int tests;
  int failed;

  // reference model state
  mst_t        m_st;
  logic [1:0]  m_xmit;
  logic        m_cplt;
  logic [15:0] m_tx;
  logic [15:0] m_lp;
  logic [2:0]  m_an;
  logic [15:0] run_q[$];
  int          idle_run;
  int          edge_n;
  int          clr_edge;
  bit          en_prev;

  vec_t tbl[14];

  pcs_an_ctrl #(.LINK_TIMER(LT), .MATCH_CNT(MATCH)) dut (
    .clk               (clk),
    .reset             (reset),
    .mr_an_enable      (mr_an_enable),
    .mr_restart_an     (mr_restart_an),
    .mr_adv_ability    (mr_adv_ability),
    .sync_status       (sync_status),
    .rx_config_valid   (rx_config_valid),
    .rx_Config_Reg     (rx_Config_Reg),
    .rx_idle           (rx_idle),
    .xmit              (xmit),
    .tx_Config_Reg     (tx_Config_Reg),
    .mr_an_complete    (mr_an_complete),
    .mr_lp_adv_ability (mr_lp_adv_ability),
    .an_state          (an_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock edge of the reference model, from the rules of the protocol:
  // a run of words with equal masked value since the last state change,
  // a count of idles since the last config word, and a timer measured in edges.
  task automatic model_step();
    logic [15:0] q[$];
    int          il;
    bit          abm, ackm, zm, im, tdone, ackall;
    logic [15:0] val;
    mst_t        nx;
    if (reset) begin
      m_st = M_EN; m_xmit = 2'd0; m_cplt = 1'b0; m_tx = 16'h0; m_lp = 16'h0; m_an = 3'd0;
      run_q.delete(); idle_run = 0; clr_edge = edge_n; en_prev = 1'b0;
      edge_n++;
      return;
    end
    q = run_q;
    if (rx_config_valid) begin
      if (q.size() > 0 && (((q[q.size()-1] ^ rx_Config_Reg) & 16'hBFFF) != 16'h0)) q.delete();
      q.push_back(rx_Config_Reg);
    end
    il = rx_config_valid ? 0 : (rx_idle ? idle_run + 1 : idle_run);
    abm = (q.size() >= MATCH);
    val = (q.size() > 0) ? (q[q.size()-1] & 16'hBFFF) : 16'h0;
    ackall = 1'b1;
    foreach (q[i]) if (!q[i][14]) ackall = 1'b0;
    ackm  = abm && ackall;
    zm    = abm && (val == 16'h0);
    im    = (il >= MATCH);
    tdone = ((edge_n - clr_edge) >= LT + 1);

    nx = m_st;
    case (m_st)
      M_EN:  nx = mr_an_enable ? M_RS : M_DIS;
      M_RS:  if (tdone) nx = M_AB;
      M_AB:  if (abm && !zm) nx = M_AK;
      M_AK:  if (zm) nx = M_EN; else if (ackm) nx = (val == m_lp) ? M_CA : M_EN;
      M_CA:  if (zm) nx = M_EN; else if (tdone) nx = M_ID;
      M_ID:  if (zm) nx = M_EN; else if (tdone && im) nx = M_OK;
      M_OK:  if (abm) nx = M_EN;
      default: if (mr_an_enable) nx = M_EN;
    endcase
    if (en_prev && !mr_an_enable && m_st != M_DIS) nx = M_EN;
    if (mr_restart_an || (mr_an_enable && !sync_status && m_st != M_EN && m_st != M_RS)) nx = M_EN;

    m_an = m_st;
    case (m_st)
      M_EN, M_RS: begin m_xmit = 2'd0; m_tx = 16'h0; m_cplt = 1'b0; end
      M_AB:       begin m_xmit = 2'd0; m_tx = mr_adv_ability & 16'hBFFF; m_cplt = 1'b0; end
      M_AK, M_CA: begin m_xmit = 2'd0; m_tx = mr_adv_ability | 16'h4000; m_cplt = 1'b0; end
      M_ID:       begin m_xmit = 2'd1; m_cplt = 1'b0; end
      M_OK:       begin m_xmit = 2'd2; m_cplt = 1'b1; end
      default:    begin m_xmit = 2'd2; m_cplt = 1'b0; end
    endcase
    if (m_st == M_AB && nx == M_AK) m_lp = val;

    if (nx != m_st) begin
      run_q.delete();
      idle_run = 0;
      if (nx == M_RS || nx == M_CA || nx == M_ID) clr_edge = edge_n;
    end else begin
      run_q = q;
      idle_run = il;
    end
    m_st = nx;
    en_prev = mr_an_enable;
    edge_n++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model", {an_state, xmit, mr_an_complete, tx_Config_Reg, mr_lp_adv_ability},
                 {m_an, m_xmit, m_cplt, m_tx, m_lp});
  endtask

  task automatic wait_st(input mst_t target, input int budget);
    int n;
    n = 0;
    while (m_st != target && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("wait_state_%0d", target), 64'(m_st), 64'(target));
  endtask

  task automatic send_cfg(input logic [15:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      rx_config_valid = 1'b1;
      rx_Config_Reg   = w;
      tick();
      rx_config_valid = 1'b0;
      tick();
    end
  endtask

  task automatic idle_until_ok();
    int n;
    n = 0;
    while (m_st != M_OK && n < 60) begin
      rx_idle = 1'b1;
      tick();
      rx_idle = 1'b0;
      tick();
      n++;
    end
    chk("wait_link_ok", 64'(m_st), 64'(M_OK));
  endtask

  task automatic bring_up(input logic [15:0] w, input bit stop_at_idle);
    wait_st(M_AB, 40);
    send_cfg(w, MATCH);
    send_cfg(w | 16'h4000, MATCH);
    wait_st(M_ID, 40);
    if (!stop_at_idle) idle_until_ok();
  endtask

  task automatic do_reset(input logic en);
    mr_an_enable = en;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] cur_word;
    logic [15:0] words[6];
    tests = 0; failed = 0;
    edge_n = 0; clr_edge = 0; idle_run = 0; en_prev = 1'b0; m_st = M_EN;
    m_xmit = 2'd0; m_cplt = 1'b0; m_tx = 16'h0; m_lp = 16'h0; m_an = 3'd0;
    reset = 1'b1; mr_an_enable = 1'b0; mr_restart_an = 1'b0; mr_adv_ability = 16'h01A0;
    sync_status = 1'b1; rx_config_valid = 1'b0; rx_Config_Reg = 16'h0; rx_idle = 1'b0;

    // rst en rs | an xmit cplt tx   (AN disabled, enable raise, restart hold, enable drop)
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 16'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 16'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 16'h0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 3'd7, 2'd2, 1'b0, 16'h0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 3'd7, 2'd2, 1'b0, 16'h0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 16'h0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 3'd1, 2'd0, 1'b0, 16'h0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 3'd1, 2'd0, 1'b0, 16'h0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 3'd0, 2'd0, 1'b0, 16'h0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 16'h0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 3'd1, 2'd0, 1'b0, 16'h0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 3'd1, 2'd0, 1'b0, 16'h0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 16'h0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 3'd7, 2'd2, 1'b0, 16'h0};

    for (int i = 0; i < 14; i++) begin
      reset         = tbl[i].rst;
      mr_an_enable  = tbl[i].en;
      mr_restart_an = tbl[i].rs;
      tick();
      chk($sformatf("vec%0d", i), {an_state, xmit, mr_an_complete, tx_Config_Reg},
          {tbl[i].an, tbl[i].xm, tbl[i].cp, tbl[i].tx});
    end
    mr_restart_an = 1'b0;

    // Normal bring-up with adv=0x01A0, partner 0x41A0
    mr_adv_ability = 16'h01A0;
    do_reset(1'b1);
    repeat (18) tick();
    chk("restart_dwell", 64'(an_state), 64'd1);
    tick();
    chk("ability_tx", {an_state, tx_Config_Reg}, {3'd2, 16'h01A0});
    send_cfg(16'h41A0, MATCH);
    chk("ack_tx", {an_state, tx_Config_Reg, mr_lp_adv_ability}, {3'd3, 16'h41A0, 16'h01A0});
    send_cfg(16'h41A0, MATCH);
    wait_st(M_ID, 40);
    tick();
    chk("idle_xmit", 64'(xmit), 64'd1);
    idle_until_ok();
    tick();
    chk("link_ok", {xmit, mr_an_complete, mr_lp_adv_ability}, {2'd2, 1'b1, 16'h01A0});

    // Link drop: three zero config words in LINK_OK
    send_cfg(16'h0000, MATCH);
    chk("link_drop", {mr_an_complete, xmit, an_state}, {1'b0, 2'd0, 3'd0});

    // Inconsistent acknowledge
    wait_st(M_AB, 40);
    send_cfg(16'h0020, MATCH);
    send_cfg(16'h4040, MATCH);
    tick();
    chk("bad_ack", {an_state, tx_Config_Reg}, {3'd1, 16'h0000});

    // Non-consecutive match
    wait_st(M_AB, 40);
    send_cfg(16'h0020, 1);
    send_cfg(16'h0040, 1);
    send_cfg(16'h0020, 2);
    chk("nonconsec_hold", 64'(an_state), 64'd2);
    send_cfg(16'h0020, 1);
    chk("nonconsec_latch", {an_state, mr_lp_adv_ability}, {3'd3, 16'h0020});

    // Reset in the middle of ACK_DETECT
    reset = 1'b1;
    tick();
    chk("reset_mid_ack", {an_state, xmit, mr_an_complete, tx_Config_Reg, mr_lp_adv_ability}, 64'd0);
    reset = 1'b0;

    // Restart on the same edge as timer_done in AN_RESTART
    repeat (17) tick();
    mr_restart_an = 1'b1;
    tick();
    mr_restart_an = 1'b0;
    tick();
    chk("restart_vs_timer", 64'(an_state), 64'd0);

    // Restart pulse in IDLE_DETECT
    bring_up(16'h01A0, 1'b1);
    mr_restart_an = 1'b1;
    tick();
    mr_restart_an = 1'b0;
    tick();
    chk("restart_in_idle", {an_state, xmit}, {3'd0, 2'd0});

    // Loss of sync in LINK_OK
    bring_up(16'h01A0, 1'b0);
    sync_status = 1'b0;
    tick();
    sync_status = 1'b1;
    tick();
    chk("sync_loss", {an_state, mr_an_complete}, {3'd0, 1'b0});

    // Randomized traffic against the model
    words[0] = 16'h41A0; words[1] = 16'h01A0; words[2] = 16'h0000;
    words[3] = 16'h0020; words[4] = 16'h4020; words[5] = 16'h4040;
    cur_word = 16'h41A0;
    do_reset(1'b1);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) cur_word = words[$urandom_range(0, 5)];
      rx_config_valid = ($urandom_range(0, 99) < 30);
      rx_Config_Reg   = rx_config_valid ? cur_word : 16'($urandom);
      rx_idle         = !rx_config_valid && ($urandom_range(0, 99) < 40);
      mr_restart_an   = ($urandom_range(0, 499) == 0);
      sync_status     = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 399) == 0) mr_an_enable = !mr_an_enable;
      if ($urandom_range(0, 149) == 0) mr_adv_ability = words[$urandom_range(0, 5)];
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
